// File: rtl/hci_bank_stall_arbiter_if.sv
// Banked HCI request/response bundle: one lane per memory bank, flattened.
// master drives requests and write data; slave returns grants and responses.
interface hci_bank_stall_arbiter_if #(
  parameter int unsigned N_MEM = 32,
  parameter int unsigned AWM   = 12,
  parameter int unsigned DW    = 32,
  parameter int unsigned BW    = 8,
  parameter int unsigned IW    = 20
);
  localparam int unsigned BEW = DW / BW;

  logic [N_MEM-1:0]       req;
  logic [N_MEM*AWM-1:0]   add;
  logic [N_MEM-1:0]       wen;
  logic [N_MEM*DW-1:0]    data;
  logic [N_MEM*BEW-1:0]   be;
  logic [N_MEM*IW-1:0]    id;
  logic [N_MEM-1:0]       gnt;
  logic [N_MEM-1:0]       r_valid;
  logic [N_MEM*DW-1:0]    r_data;

  modport master (
    output req, add, wen, data, be, id,
    input  gnt, r_valid, r_data
  );

  modport slave (
    input  req, add, wen, data, be, id,
    output gnt, r_valid, r_data
  );
endinterface

// File: rtl/hci_bank_stall_arbiter.sv
// Per-bank log/hwpe arbiter with starvation bound and response routing.
// Optional forced-grant counter: define HCI_BANK_ARB_PERF_EN.
module hci_bank_stall_arbiter #(
  parameter int unsigned N_MEM = 32,
  parameter int unsigned AWM   = 12,
  parameter int unsigned DW    = 32,
  parameter int unsigned BW    = 8,
  parameter int unsigned IW    = 20,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             invert_prio_i,
  input  logic [CNT_W-1:0] max_stall_i,
  hci_bank_stall_arbiter_if.slave  log,
  hci_bank_stall_arbiter_if.slave  hwpe,
  hci_bank_stall_arbiter_if.master mem
`ifdef HCI_BANK_ARB_PERF_EN
  ,
  output logic [31:0]      perf_forced_o
`endif
);
  localparam int unsigned BEW = DW / BW;

  logic [N_MEM-1:0] hi_req;
  logic [N_MEM-1:0] lo_req;
  logic [N_MEM-1:0] sel_lo;
  logic [N_MEM-1:0] sel_log;
  logic [N_MEM-1:0] lo_hs;
  logic [N_MEM-1:0] hs;
  logic [N_MEM-1:0] force_q;
  logic [N_MEM-1:0] force_d;
  logic [N_MEM-1:0] vld_q;
  logic [N_MEM-1:0] src_q;
  logic [CNT_W-1:0] cnt_q   [N_MEM];
  logic [CNT_W-1:0] cnt_d   [N_MEM];
  logic [CNT_W-1:0] cnt_inc [N_MEM];

  always_comb begin
    hi_req  = invert_prio_i ? log.req  : hwpe.req;
    lo_req  = invert_prio_i ? hwpe.req : log.req;
    sel_lo  = lo_req & (~hi_req | force_q);
    // lo is the log branch unless priority is inverted
    sel_log = sel_lo ^ {N_MEM{invert_prio_i}};
    lo_hs   = sel_lo & mem.gnt;
    hs      = mem.req & mem.gnt;
  end

  for (genvar b = 0; b < N_MEM; b++) begin : g_bank
    assign mem.add[b*AWM +: AWM] = sel_log[b] ?
      log.add[b*AWM +: AWM] : hwpe.add[b*AWM +: AWM];
    assign mem.data[b*DW +: DW] = sel_log[b] ?
      log.data[b*DW +: DW] : hwpe.data[b*DW +: DW];
    assign mem.be[b*BEW +: BEW] = sel_log[b] ?
      log.be[b*BEW +: BEW] : hwpe.be[b*BEW +: BEW];
    assign mem.id[b*IW +: IW] = sel_log[b] ?
      log.id[b*IW +: IW] : hwpe.id[b*IW +: IW];
    assign mem.wen[b] = sel_log[b] ? log.wen[b] : hwpe.wen[b];
  end

  assign mem.req      = log.req | hwpe.req;
  assign log.gnt      = mem.gnt & log.req & sel_log;
  assign hwpe.gnt     = mem.gnt & hwpe.req & ~sel_log;
  assign log.r_valid  = vld_q & src_q;
  assign hwpe.r_valid = vld_q & ~src_q;
  assign log.r_data   = mem.r_data;
  assign hwpe.r_data  = mem.r_data;

  always_comb begin
    force_d = force_q;
    for (int b = 0; b < N_MEM; b++) begin
      cnt_d[b]   = cnt_q[b];
      cnt_inc[b] = (&cnt_q[b]) ? cnt_q[b] : cnt_q[b] + 1'b1;
      if (clear_i || lo_hs[b]) begin
        cnt_d[b]   = '0;
        force_d[b] = 1'b0;
      end else if (lo_req[b]) begin
        cnt_d[b] = cnt_inc[b];
        if ((max_stall_i != '0) && (cnt_inc[b] >= max_stall_i))
          force_d[b] = 1'b1;
      end else if (force_q[b]) begin
        // lo withdrew while a forced slot was pending
        cnt_d[b]   = '0;
        force_d[b] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < N_MEM; b++) cnt_q[b] <= '0;
      force_q <= '0;
      vld_q   <= '0;
      src_q   <= '0;
    end else begin
      for (int b = 0; b < N_MEM; b++) cnt_q[b] <= cnt_d[b];
      force_q <= force_d;
      vld_q   <= hs & {N_MEM{~clear_i}};
      src_q   <= (hs & sel_log) | (~hs & src_q);
    end
  end

`ifdef HCI_BANK_ARB_PERF_EN
  localparam int unsigned PW = $clog2(N_MEM + 1);

  logic [N_MEM-1:0] forced_hs;
  logic [PW-1:0]    n_forced;
  logic [31:0]      perf_q;

  always_comb begin
    forced_hs = lo_hs & force_q;
    n_forced  = '0;
    for (int b = 0; b < N_MEM; b++)
      n_forced = n_forced + {{(PW-1){1'b0}}, forced_hs[b]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_q <= '0;
    else if (clear_i) perf_q <= '0;
    else perf_q <= perf_q + 32'(n_forced);
  end

  assign perf_forced_o = perf_q;
`endif
endmodule

// File: tb/tb_hci_bank_stall_arbiter.sv
// Scoreboard bench for hci_bank_stall_arbiter: directed bank scenarios,
// grant/response events checked in bank order by a negedge monitor.
module tb_hci_bank_stall_arbiter;
  localparam int N   = 32;
  localparam int AWM = 12;
  localparam int DW  = 32;
  localparam int BW  = 8;
  localparam int IW  = 20;
  localparam int CW  = 8;

  typedef struct packed {
    logic        rsp;
    logic        br;
    logic [7:0]  bank;
    logic [31:0] val;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          invert;
  logic [CW-1:0] max_stall;
  logic [31:0]   perf;
  logic [31:0]   rdata;
  int            cyc;
  int            n_vec = 0;
  int            n_bad = 0;
  ev_t           q[$];

  hci_bank_stall_arbiter_if #(N, AWM, DW, BW, IW) log_if ();
  hci_bank_stall_arbiter_if #(N, AWM, DW, BW, IW) hwpe_if ();
  hci_bank_stall_arbiter_if #(N, AWM, DW, BW, IW) mem_if ();

  hci_bank_stall_arbiter #(
    .N_MEM(N), .AWM(AWM), .DW(DW), .BW(BW), .IW(IW), .CNT_W(CW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .invert_prio_i (invert),
    .max_stall_i   (max_stall),
    .log           (log_if),
    .hwpe          (hwpe_if),
    .mem           (mem_if)
`ifdef HCI_BANK_ARB_PERF_EN
    ,
    .perf_forced_o (perf)
`endif
  );

`ifndef HCI_BANK_ARB_PERF_EN
  assign perf = '0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic see(input ev_t o);
    ev_t e;
    n_vec++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected event at cyc %0d: got %h, want none",
               cyc, o);
    end else begin
      e = q.pop_front();
      if (o !== e) begin
        n_bad++;
        $display("FAIL event at cyc %0d: got %h, want %h", cyc, o, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int b = 0; b < N; b++) begin
        if (log_if.gnt[b])
          see('{1'b0, 1'b0, 8'(b), 32'(mem_if.add[b*AWM +: AWM])});
        if (hwpe_if.gnt[b])
          see('{1'b0, 1'b1, 8'(b), 32'(mem_if.add[b*AWM +: AWM])});
        if (log_if.r_valid[b])
          see('{1'b1, 1'b0, 8'(b), log_if.r_data[b*DW +: DW]});
        if (hwpe_if.r_valid[b])
          see('{1'b1, 1'b1, 8'(b), hwpe_if.r_data[b*DW +: DW]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rdata = {8'hC3, 16'h0, cyc[7:0]};
    mem_if.r_data = {N{rdata}};
  endtask

  task automatic exp_g(input bit br, input int b);
    q.push_back('{1'b0, br, 8'(b), br ? 32'h200 + b : 32'h100 + b});
  endtask

  task automatic exp_r(input bit br, input int b);
    q.push_back('{1'b1, br, 8'(b), rdata});
  endtask

  task automatic set_req(input int b, input bit l, input bit h);
    log_if.req[b]  = l;
    hwpe_if.req[b] = h;
  endtask

  initial begin
    bit prev;
    bit br;
    rst_n     = 1'b0;
    clear     = 1'b0;
    invert    = 1'b0;
    max_stall = '0;
    cyc       = 0;
    rdata     = '0;
    log_if.req  = '0;
    hwpe_if.req = '0;
    log_if.wen  = '1;
    hwpe_if.wen = '1;
    log_if.data  = '0;
    hwpe_if.data = '1;
    log_if.be  = '1;
    hwpe_if.be = '1;
    log_if.id  = '0;
    hwpe_if.id = '1;
    for (int b = 0; b < N; b++) begin
      log_if.add[b*AWM +: AWM]  = AWM'(12'h100 + b);
      hwpe_if.add[b*AWM +: AWM] = AWM'(12'h200 + b);
    end
    mem_if.gnt     = '1;
    mem_if.r_valid = '0;
    mem_if.r_data  = '0;

    #3;
    chk("rst_log_rvalid", log_if.r_valid, 32'h0);
    chk("rst_hwpe_rvalid", hwpe_if.r_valid, 32'h0);
    chk("rst_gnt", log_if.gnt | hwpe_if.gnt, 32'h0);
    chk("rst_mem_req", mem_if.req, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_gnt", log_if.gnt | hwpe_if.gnt, 32'h0);
    chk("idle_rvalid", log_if.r_valid | hwpe_if.r_valid, 32'h0);
    chk("idle_mem_req", mem_if.req, 32'h0);

    // fixed priority: hwpe wins every cycle
    for (int i = 0; i < 10; i++) begin
      tick();
      set_req(3, 1, 1);
      exp_g(1, 3);
      if (i > 0) exp_r(1, 3);
    end
    tick();
    set_req(3, 0, 0);
    exp_r(1, 3);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // starvation bound 4: hwpe x4, log x1
    max_stall = 8'd4;
    prev = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      set_req(0, 1, 1);
      br = (i % 5 == 4) ? 1'b0 : 1'b1;
      exp_g(br, 0);
      if (i > 0) exp_r(prev, 0);
      prev = br;
    end
    tick();
    set_req(0, 0, 0);
    exp_r(prev, 0);
    max_stall = '0;

    // response routing: log read then hwpe write
    tick();
    set_req(1, 1, 0);
    exp_g(0, 1);
    tick();
    set_req(1, 0, 1);
    hwpe_if.wen[1] = 1'b0;
    exp_g(1, 1);
    exp_r(0, 1);
    #1;
    chk("wen_mux", 32'(mem_if.wen[1]), 32'h0);
    tick();
    set_req(1, 0, 0);
    hwpe_if.wen[1] = 1'b1;
    exp_r(1, 1);

    // bank stalls with max_stall=2: force builds, log gets first grant
    max_stall = 8'd2;
    mem_if.gnt[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      set_req(2, 1, 1);
    end
    tick();
    mem_if.gnt[2] = 1'b1;
    exp_g(0, 2);
    tick();
    set_req(2, 0, 0);
    exp_r(0, 2);
    max_stall = '0;

    // inverted priority: log wins
    tick();
    invert = 1'b1;
    set_req(4, 1, 1);
    exp_g(0, 4);
    tick();
    set_req(4, 0, 1);
    exp_g(1, 4);
    exp_r(0, 4);
    tick();
    set_req(4, 0, 0);
    invert = 1'b0;
    exp_r(1, 4);

    // clear: granted, response suppressed
    tick();
    clear = 1'b1;
    set_req(5, 0, 1);
    exp_g(1, 5);
    tick();
    clear = 1'b0;
    set_req(5, 0, 0);
    tick();

    // reset mid-flight drops the pending response
    tick();
    set_req(6, 0, 1);
    exp_g(1, 6);
    tick();
    rst_n = 1'b0;
    set_req(6, 0, 0);
    #1;
    rst_n = 1'b1;
    tick();
    tick();

`ifdef HCI_BANK_ARB_PERF_EN
    clear = 1'b1;
    tick();
    clear = 1'b0;
    max_stall = 8'd4;
    prev = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      br = (i % 5 == 4) ? 1'b0 : 1'b1;
      for (int b = 0; b < 2; b++) begin
        set_req(b, 1, 1);
        exp_g(br, b);
        if (i > 0) exp_r(prev, b);
      end
      prev = br;
    end
    tick();
    set_req(0, 0, 0);
    set_req(1, 0, 0);
    exp_r(prev, 0);
    exp_r(prev, 1);
    chk("perf_forced", perf, 32'd20);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("perf_clear", perf, 32'd0);
    max_stall = '0;
`endif

    tick();
    tick();
    while (q.size() > 0) begin
      ev_t e;
      e = q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL missing event: got none, want %h", e);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
